// File: rtl/rob_walk_ctrl.sv
// rtl/rob_walk_ctrl.sv - ROB squash walker: emits up to two squashed entries per cycle, youngest first, then reloads the tail.
module rob_walk_ctrl #(
   parameter int ROB_SIZE     = 64,
   parameter int ROB_SIZE_LOG = 6
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    redirect_valid,
   input  logic                    redirect_robflag,
   input  logic [ROB_SIZE_LOG-1:0] redirect_robidx,
   input  logic                    rob_enq_flag,
   input  logic [ROB_SIZE_LOG-1:0] rob_enq_idx,
   output logic                    walk0_valid,
   output logic [ROB_SIZE_LOG-1:0] walk0_robidx,
   output logic                    walk1_valid,
   output logic [ROB_SIZE_LOG-1:0] walk1_robidx,
   output logic                    walk_busy,
   output logic                    tail_set_valid,
   output logic                    tail_set_flag,
   output logic [ROB_SIZE_LOG-1:0] tail_set_idx
);

   localparam int W  = ROB_SIZE_LOG;
   localparam int PW = ROB_SIZE_LOG + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WALK = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] tgt_q, tgt_d;
   logic [PW-1:0] rem_q, rem_d;

   logic [PW-1:0] redir_ptr;
   logic [PW-1:0] enq_last;
   logic [PW-1:0] walk_n;
   logic [PW-1:0] ptr_walked;
   logic [PW-1:0] rem_walked;
   logic [PW-1:0] rem_nested;
   logic [PW-1:0] tail_ptr;
   logic          walk0, walk1;
   logic          redir_older;
   logic          redir_take;

   assign redir_ptr = {redirect_robflag, redirect_robidx};
   assign enq_last  = {rob_enq_flag, rob_enq_idx} - PW'(1);

   assign walk0 = (state_q == S_WALK) && (rem_q != '0);
   assign walk1 = (state_q == S_WALK) && (rem_q >= PW'(2));

   assign walk_n     = walk1 ? PW'(2) : (walk0 ? PW'(1) : '0);
   assign ptr_walked = ptr_q - walk_n;
   assign rem_walked = rem_q - walk_n;

   // With differing wrap flags the older entry sits at the higher index.
   assign redir_older = (redirect_robflag == tgt_q[W]) ? (redirect_robidx < tgt_q[W-1:0])
                                                       : (redirect_robidx > tgt_q[W-1:0]);
   assign redir_take  = redirect_valid && (state_q != S_IDLE) && redir_older;
   assign rem_nested  = ((state_q == S_WALK) ? ptr_walked : ptr_q) - redir_ptr;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      tgt_d   = tgt_q;
      rem_d   = rem_q;
      case (state_q)
         S_IDLE: begin
            if (redirect_valid) begin
               tgt_d   = redir_ptr;
               ptr_d   = enq_last;
               rem_d   = enq_last - redir_ptr;
               state_d = ((enq_last - redir_ptr) != '0) ? S_WALK : S_DONE;
            end
         end
         S_WALK: begin
            ptr_d = ptr_walked;
            if (redir_take) begin
               tgt_d   = redir_ptr;
               rem_d   = rem_nested;
               state_d = (rem_nested != '0) ? S_WALK : S_DONE;
            end else begin
               rem_d   = rem_walked;
               state_d = (rem_walked != '0) ? S_WALK : S_DONE;
            end
         end
         S_DONE: begin
            if (redir_take) begin
               tgt_d   = redir_ptr;
               rem_d   = rem_nested;
               state_d = (rem_nested != '0) ? S_WALK : S_DONE;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         tgt_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         tgt_q   <= tgt_d;
         rem_q   <= rem_d;
      end
   end

   assign tail_ptr = tgt_q + PW'(1);

   assign walk0_valid  = walk0;
   assign walk0_robidx = walk0 ? ptr_q[W-1:0] : '0;
   assign walk1_valid  = walk1;
   assign walk1_robidx = !walk1 ? '0 :
                         (ptr_q[W-1:0] == '0) ? W'(ROB_SIZE - 1) : (ptr_q[W-1:0] - W'(1));

   assign walk_busy      = (state_q != S_IDLE);
   // A nested redirect landing in DONE restarts the walk, so the old tail must not load.
   assign tail_set_valid = (state_q == S_DONE) && !redir_take;
   assign tail_set_flag  = (state_q == S_DONE) ? tail_ptr[W] : 1'b0;
   assign tail_set_idx   = (state_q == S_DONE) ? tail_ptr[W-1:0] : '0;

endmodule
